// File: rtl/register_file_mp.sv
// Multi-read-port register file with same-cycle write bypass and a hardware clear
// sequencer. Define REGFILE_ZERO_REG_EN to hardwire entry 0 to zero.
module register_file_mp #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_READ   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           register_load,
  input  logic [ADDR_WIDTH-1:0]          address_D,
  input  logic [DATA_WIDTH-1:0]          bus_D,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] address_R,
  output logic [NUM_READ*DATA_WIDTH-1:0] bus_R,
  input  logic                           clear_req,
  output logic                           clear_busy,
  output logic                           clear_done
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZeroReg = 1'b1;
`else
  localparam bit ZeroReg = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  fwd_en;

  // The clear sequencer borrows the single write port, so writeback is locked out while it runs.
  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d = state_q;
    cnt_d   = cnt_q;
    wr_en   = 1'b0;
    wr_addr = address_D;
    wr_data = bus_D;
    unique case (state_q)
      ST_IDLE: begin
        wr_en = register_load;
        if (clear_req) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      ST_CLEAR: begin
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = '0;
        cnt_d   = cnt_q + ADDR_WIDTH'(1);
        if (&cnt_q) state_d = ST_DONE;
      end
      ST_DONE: begin
        wr_en   = register_load;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (ZeroReg && wr_addr == '0) wr_en = 1'b0;
    busy_d = (state_d == ST_CLEAR);
    done_d = (state_d == ST_DONE);
  end

  assign fwd_en = register_load && (state_q != ST_CLEAR) && !(ZeroReg && address_D == '0);

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    // NOTE: the array is reset on purpose; reset must leave every entry reading zero.
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  for (genvar k = 0; k < NUM_READ; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] ra;
    assign ra = address_R[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign bus_R[k*DATA_WIDTH +: DATA_WIDTH] =
        (fwd_en && ra == address_D) ? bus_D :
        (ZeroReg && ra == '0)       ? '0    : mem_q[ra];
  end

  assign clear_busy = busy_q;
  assign clear_done = done_q;

endmodule
